uart_tx_sched: RTL
==================

# uart_tx_sched

Round-robin transmit scheduler that shares one `UART_TX` serializer among `NUM_REQ` byte producers. It accepts one byte per grant from a valid/ready requester port and attaches that requester's parity configuration. It drives `P_DATA`/`Data_Valid`/`PAR_EN`/`PAR_TYP` into `UART_TX`, then tracks `busy` until the frame completes before granting again. It sits directly in front of `UART_TX` in the UART TX subsystem.

## Interface
- `NUM_REQ`, 2: number of requesters, legal range 2..4.
- `GAP_CYCLES`, 2: idle cycles inserted after each frame; only used when `UART_TX_SCHED_GAP_EN` is defined; legal range 1..15.
- `clk`  in  1  system clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  requester i has a byte pending.
- `req_data`  in  8*NUM_REQ  byte for requester i, at bits [8i+7:8i]; must stay stable while `req_valid[i]` is high and `req_ready[i]` is low.
- `cfg_par_en`  in  NUM_REQ  parity enable for requester i.
- `cfg_par_typ`  in  NUM_REQ  parity type for requester i: 0 = even, 1 = odd.
- `req_ready`  out  NUM_REQ  one-hot one-cycle accept strobe.
- `P_DATA`  out  8  byte to `UART_TX`.
- `Data_Valid`  out  1  one-cycle start strobe to `UART_TX`.
- `PAR_EN`, `PAR_TYP`  out  1 each  parity controls to `UART_TX`.
- `busy`  in  1  `UART_TX` busy.
- `grant_id`  out  $clog2(NUM_REQ)  requester owning the current or last frame.
- `frame_done`  out  1  one-cycle pulse on busy falling edge.
- `err_no_busy`  out  1  sticky flag; set if `busy` is not seen after a start; cleared only by reset.

## Operation
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP. GAP exists only when `UART_TX_SCHED_GAP_EN` is defined.
- **IDLE** (arbitration):
  - If any `req_valid` is high, the winner g is the first valid index searched from `last_grant+1` modulo NUM_REQ.
  - `req_ready[g]` is asserted combinationally in that same cycle.
  - On that edge the block captures `req_data[g]`, `cfg_par_en[g]` and `cfg_par_typ[g]` into the holding registers, and updates `grant_id` and `last_grant` to g.
  - Next state: ISSUE.
- **ISSUE**: `Data_Valid` = 1 for exactly this cycle. Next state: WAIT_BUSY.
- **WAIT_BUSY**:
  - `busy` = 1 → WAIT_DONE.
  - `busy` still 0 after 2 cycles in this state → set `err_no_busy` and go to IDLE (frame dropped).
- **WAIT_DONE**: on `busy` = 0, pulse `frame_done` and go to GAP (or IDLE when `UART_TX_SCHED_GAP_EN` is not defined).
- **GAP**: count GAP_CYCLES cycles, then go to IDLE.
- `P_DATA`, `PAR_EN` and `PAR_TYP` come from the holding registers and stay constant from ISSUE through the end of WAIT_DONE. A requester changing its `req_data` after accept has no effect on the frame in flight.
- `req_ready` is 0 in every state except IDLE. At most one requester is accepted per frame.
- A requester that deasserts `req_valid` before being granted is simply skipped. No error is raised.
- `cfg_par_*` is sampled only at grant. Changes during a frame apply to the next grant.

## Timing
- Reset values:
  - All outputs are 0, including `err_no_busy` and `grant_id`.
  - `last_grant` resets to NUM_REQ-1, so requester 0 has first priority after reset.
  - State resets to IDLE.
- Latency:
  - `req_valid` is high in IDLE cycle k → `req_ready` is high in cycle k and `Data_Valid` is high in cycle k+1.
  - `UART_TX` raises `busy` at k+2.
- Frame slot length:
  - Without gap: 3 + (busy-high cycles). The next accept is no earlier than the cycle after `frame_done`.
  - With gap: add GAP_CYCLES.
- Simultaneous requests rotate strictly. With all NUM_REQ valid continuously, grants are cyclic 0,1,…,NUM_REQ-1,0…
- Reset asserted mid-frame: state returns to IDLE immediately (asynchronous) and `Data_Valid` drops. The in-flight frame is abandoned. `UART_TX` shares the same reset.
- `busy` falling and a new `req_valid` in the same cycle: `frame_done` pulses that cycle. The grant happens no earlier than the next cycle.

## Configuration
- `UART_TX_SCHED_GAP_EN`:
  - Defined: the GAP state and a 4-bit gap counter are compiled in, giving GAP_CYCLES idle cycles (line held at `TX_OUT` idle) between consecutive frames.
  - Undefined: WAIT_DONE goes straight to IDLE and GAP_CYCLES is ignored.

## Test plan
- Single requester, NUM_REQ=2:
  - Stimulus: `req_valid[0]`=1, `req_data`=8'h0A, `cfg_par_en[0]`=1, `cfg_par_typ[0]`=0.
  - Required: `req_ready[0]` in the same cycle; `Data_Valid` exactly 1 cycle; `P_DATA`=0x0A, `PAR_EN`=1, `PAR_TYP`=0 held until `frame_done`; `TX_OUT` frame is 11 bits with parity 0.
- Contention:
  - Stimulus: both valid continuously with bytes 0x16 and 0x64.
  - Required: grants 0,1,0,1; `grant_id` matches; no overlapping `Data_Valid` while `busy`=1.
- Data change after accept:
  - Stimulus: requester 1 changes `req_data` from 0x17 to random values during the frame.
  - Required: transmitted bits [8:1] = 0x17; odd parity bit is correct.
- Busy never asserts:
  - Stimulus: `busy` forced to 0.
  - Required: `err_no_busy` = 1 two cycles after ISSUE; FSM returns to IDLE; the next request is still served.
- Mid-frame reset:
  - Stimulus: `rst`=0 during WAIT_DONE.
  - Required: all outputs 0 at once; after release, requester 0 is granted first.
- With `UART_TX_SCHED_GAP_EN`, GAP_CYCLES=3:
  - Required: exactly 3 cycles between `frame_done` and the next `req_ready`.

Source files
------------

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART_TX serializer among NUM_REQ byte producers.
// Define UART_TX_SCHED_GAP_EN to insert GAP_CYCLES idle cycles after every frame.
module uart_tx_sched #(
    parameter int NUM_REQ    = 2,
    parameter int GAP_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [8*NUM_REQ-1:0]         req_data,
    input  logic [NUM_REQ-1:0]           cfg_par_en,
    input  logic [NUM_REQ-1:0]           cfg_par_typ,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [7:0]                   P_DATA,
    output logic                         Data_Valid,
    output logic                         PAR_EN,
    output logic                         PAR_TYP,
    input  logic                         busy,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         frame_done,
    output logic                         err_no_busy
);

    // state       | meaning
    // S_IDLE      | arbitrate, accept one byte from the round-robin winner
    // S_ISSUE     | one-cycle Data_Valid strobe to UART_TX
    // S_WAIT_BUSY | wait up to two cycles for busy to rise
    // S_WAIT_DONE | frame in flight, wait for busy to fall
    // S_GAP       | inter-frame idle time (gap build only)

    localparam int GW = $clog2(NUM_REQ);

    generate
        if (NUM_REQ < 2 || NUM_REQ > 4 || GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_bad_param
            $error("uart_tx_sched: NUM_REQ must be 2..4 and GAP_CYCLES 1..15");
        end
    endgenerate

`ifdef UART_TX_SCHED_GAP_EN
    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_GAP
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE
    } state_t;
`endif

    state_t          state_q, state_d;
    logic [7:0]      data_q, data_d;
    logic            par_en_q, par_en_d;
    logic            par_typ_q, par_typ_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_q, last_d;
    logic            err_q, err_d;
    logic            wb_cnt_q, wb_cnt_d;
`ifdef UART_TX_SCHED_GAP_EN
    logic [3:0]      gap_cnt_q, gap_cnt_d;
`endif

    logic            win_found;
    logic [GW-1:0]   win_idx;
    logic [GW-1:0]   cand_idx;
    logic [7:0]      sel_data;

    // Walk from the farthest offset down so the nearest valid requester after last_q wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_idx  = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand_idx = GW'((int'(last_q) + off) % NUM_REQ);
            if (req_valid[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (GW'(i) == win_idx) begin
                sel_data = req_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        grant_d    = grant_q;
        last_d     = last_q;
        err_d      = err_q;
        wb_cnt_d   = wb_cnt_q;
`ifdef UART_TX_SCHED_GAP_EN
        gap_cnt_d  = gap_cnt_q;
`endif
        req_ready  = '0;
        Data_Valid = 1'b0;
        frame_done = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    req_ready = rst ? (NUM_REQ'(1) << win_idx) : '0;
                    data_d    = sel_data;
                    par_en_d  = cfg_par_en[win_idx];
                    par_typ_d = cfg_par_typ[win_idx];
                    grant_d   = win_idx;
                    last_d    = win_idx;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                Data_Valid = 1'b1;
                wb_cnt_d   = 1'b0;
                state_d    = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (busy) begin
                    state_d = S_WAIT_DONE;
                end else if (wb_cnt_q) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wb_cnt_d = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!busy) begin
                    frame_done = 1'b1;
`ifdef UART_TX_SCHED_GAP_EN
                    gap_cnt_d  = 4'(GAP_CYCLES - 1);
                    state_d    = S_GAP;
`else
                    state_d    = S_IDLE;
`endif
                end
            end
`ifdef UART_TX_SCHED_GAP_EN
            S_GAP: begin
                if (gap_cnt_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            grant_q   <= '0;
            last_q    <= GW'(NUM_REQ - 1);
            err_q     <= 1'b0;
            wb_cnt_q  <= 1'b0;
`ifdef UART_TX_SCHED_GAP_EN
            gap_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            err_q     <= err_d;
            wb_cnt_q  <= wb_cnt_d;
`ifdef UART_TX_SCHED_GAP_EN
            gap_cnt_q <= gap_cnt_d;
`endif
        end
    end

    assign P_DATA      = data_q;
    assign PAR_EN      = par_en_q;
    assign PAR_TYP     = par_typ_q;
    assign grant_id    = grant_q;
    assign err_no_busy = err_q;

endmodule
